div_seq_signed: RTL and testbench

Sequential signed integer divider that pairs with the signed sign-magnitude multiplier in the arithmetic library. It computes quotient and remainder of a two's-complement dividend by a two's-complement divisor using restoring division on magnitudes, then restores signs. Results truncate toward zero. Latency is constant and data-independent, so the block garbles to a fixed netlist per cycle. It is intended as the sequential divide primitive for datapaths built from the synthesis library.

---
 rtl/div_seq_signed_if.sv | 25 ++
 rtl/div_seq_signed.sv | 150 +++++++++++++++
 tb/tb_div_seq_signed.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_signed_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_signed_if
//  Description : Request/result bundle for the sequential signed divider.
//                master = requester side, slave = divider side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_seq_signed_if #(
    parameter int N = 8,
    parameter int M = 8
);
    logic         start;
    logic [N-1:0] A;
    logic [M-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] Q;
    logic [M-1:0] R;
    logic         dz;
    logic         ovf;

    modport master (output start, A, B, input busy, done, Q, R, dz, ovf);
    modport slave  (input start, A, B, output busy, done, Q, R, dz, ovf);
endinterface
`default_nettype wire

// File: rtl/div_seq_signed.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_signed
//  Description : Sequential signed divider. Restoring division on magnitudes,
//                one quotient bit per cycle, then sign restoration. Results
//                truncate toward zero; latency is a fixed N+1 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq_signed #(
    parameter int N = 8,
    parameter int M = 8
) (
    input wire           clk,
    input wire           rst,
    div_seq_signed_if.slave bus
);
    localparam int         c_cnt_w = (N > 2) ? $clog2(N) : 1;
    localparam [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N - 1);
    localparam [N-1:0]     c_q_min = {1'b1, {(N-1){1'b0}}};

    localparam [1:0] c_idle = 2'd0;
    localparam [1:0] c_calc = 2'd1;
    localparam [1:0] c_fix  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_busy;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_sa;
    logic               r_sb;
    logic               r_dz;
    // Holds |A| at capture; quotient bits shift in at the LSB as dividend
    // bits shift out at the MSB, so it ends up holding qmag.
    logic [N-1:0]       r_work;
    logic [M-1:0]       r_bmag;
    logic [M-1:0]       r_rem;
    logic [M-1:0]       r_a_ext;
    logic [N-1:0]       r_q;
    logic [M-1:0]       r_r;
    logic               r_dz_o;
    logic               r_ovf;
    logic               r_done;

    logic [N-1:0]       w_amag;
    logic [M-1:0]       w_bmag;
    logic [N+M-1:0]     w_a_wide;
    logic [M:0]         w_trial;
    logic               w_ge;
    logic [M-1:0]       w_diff;
    logic [N-1:0]       w_qneg;
    logic [M-1:0]       w_rneg;

    assign w_amag   = bus.A[N-1] ? (~bus.A + N'(1)) : bus.A;
    assign w_bmag   = bus.B[M-1] ? (~bus.B + M'(1)) : bus.B;
    assign w_a_wide = (N+M)'($signed(bus.A));

    // Trial remainder is M+1 bits; the kept remainder is always < |B| so
    // the low M bits of the difference are exact.
    assign w_trial = {r_rem, r_work[N-1]};
    assign w_ge    = (w_trial >= {1'b0, r_bmag});
    assign w_diff  = w_trial[M-1:0] - r_bmag;
    assign w_qneg  = ~r_work + N'(1);
    assign w_rneg  = ~r_rem + M'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= c_idle;
        else      r_state <= w_state_nxt;
    end

    // Next-state and busy decode
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            c_idle: if (bus.start) w_state_nxt = c_calc;
            c_calc: begin
                w_busy = 1'b1;
                if (r_cnt == c_cnt_last) w_state_nxt = c_fix;
            end
            c_fix: begin
                w_busy      = 1'b1;
                w_state_nxt = c_idle;
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    // Operand capture, iteration and result write-back
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_dz    <= 1'b0;
            r_work  <= '0;
            r_bmag  <= '0;
            r_rem   <= '0;
            r_a_ext <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_dz_o  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (bus.start) begin
                        r_sa    <= bus.A[N-1];
                        r_sb    <= bus.B[M-1];
                        r_work  <= w_amag;
                        r_bmag  <= w_bmag;
                        r_dz    <= (bus.B == '0);
                        r_a_ext <= w_a_wide[M-1:0];
                        r_rem   <= '0;
                        r_cnt   <= '0;
                    end
                end
                c_calc: begin
                    r_rem  <= w_ge ? w_diff : w_trial[M-1:0];
                    r_work <= {r_work[N-2:0], w_ge};
                    r_cnt  <= (r_cnt == c_cnt_last) ? '0 : r_cnt + c_cnt_w'(1);
                end
                c_fix: begin
                    r_done <= 1'b1;
                    r_dz_o <= r_dz;
                    if (r_dz) begin
                        r_q   <= '1;
                        r_r   <= r_a_ext;
                        r_ovf <= 1'b0;
                    end else begin
                        r_q   <= (r_sa ^ r_sb) ? w_qneg : r_work;
                        r_r   <= r_sa ? w_rneg : r_rem;
                        r_ovf <= !(r_sa ^ r_sb) && (r_work == c_q_min);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.Q    = r_q;
    assign bus.R    = r_r;
    assign bus.dz   = r_dz_o;
    assign bus.ovf  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_div_seq_signed.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_seq_signed
//  Description : Self-checking bench for div_seq_signed (N=M=8) against an
//                integer-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_signed;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    div_seq_signed_if #(.N(8), .M(8)) dif ();

    div_seq_signed #(.N(8), .M(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: C-style truncating division, with the divide-by-zero and
    // overflow rules applied on top.
    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ovf);
        int ai, bi, qi, ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            q = 8'hFF; r = a; dz = 1'b1; ovf = 1'b0;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            q = qi[7:0]; r = ri[7:0]; dz = 1'b0; ovf = (qi == 128);
        end
    endtask

    // Issue one request and return the cycles from accept edge to done (-1 on timeout).
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        dif.start = 1'b1; dif.A = a; dif.B = b;
        @(posedge clk); #1;
        dif.start = 1'b0; dif.A = 8'($urandom); dif.B = 8'($urandom);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (dif.done) begin lat = c; break; end
        end
    endtask

    task automatic test_reset();
        dif.start = 1'b0; dif.A = '0; dif.B = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({dif.busy, dif.done, dif.Q, dif.R, dif.dz, dif.ovf} !== 20'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b Q=%h R=%h dz=%b ovf=%b exp all zero",
                     dif.busy, dif.done, dif.Q, dif.R, dif.dz, dif.ovf);
        end
        // start coincident with reset must be dropped
        @(negedge clk); dif.start = 1'b1; dif.A = 8'd10; dif.B = 8'd3;
        @(posedge clk); #1;
        dif.start = 1'b0;
        checks++;
        if (dif.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_start got busy=%b exp 0", dif.busy);
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] ta [7];
        logic [7:0] tb [7];
        logic [7:0] eq [7];
        logic [7:0] er [7];
        logic       edz [7];
        logic       eov [7];
        int lat;
        ta = '{8'd100, 8'h9C, 8'd100, 8'h9C, 8'h80, 8'h80, 8'd5};
        tb = '{8'd7,   8'd7,  8'hF9,  8'hF9,  8'hFF, 8'd1,  8'd0};
        eq = '{8'h0E,  8'hF2, 8'hF2,  8'h0E,  8'h80, 8'h80, 8'hFF};
        er = '{8'h02,  8'hFE, 8'h02,  8'hFE,  8'h00, 8'h00, 8'h05};
        edz = '{0, 0, 0, 0, 0, 0, 1};
        eov = '{0, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 7; i++) begin
            do_op(ta[i], tb[i], lat);
            checks++;
            if (lat != 9 || dif.Q !== eq[i] || dif.R !== er[i] ||
                dif.dz !== edz[i] || dif.ovf !== eov[i]) begin
                errors++;
                $display("FAIL directed_%0d A=%h B=%h got lat=%0d Q=%h R=%h dz=%b ovf=%b exp lat=9 Q=%h R=%h dz=%b ovf=%b",
                         i, ta[i], tb[i], lat, dif.Q, dif.R, dif.dz, dif.ovf,
                         eq[i], er[i], edz[i], eov[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (dif.done !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse_width_%0d got done=%b exp 0", i, dif.done);
            end
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        ndone = 0;
        @(negedge clk);
        dif.start = 1'b1; dif.A = 8'd100; dif.B = 8'd7;
        @(posedge clk); #1;
        dif.start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            if (dif.done) ndone++;
            @(negedge clk);
            dif.start = ((c + 1) == 3) || ((c + 1) == 8);
            dif.A = 8'd50; dif.B = 8'd3;
        end
        dif.start = 1'b0;
        checks++;
        if (ndone != 1 || dif.Q !== 8'd14 || dif.R !== 8'd2) begin
            errors++;
            $display("FAIL ignore_start got dones=%0d Q=%h R=%h exp dones=1 Q=0e R=02",
                     ndone, dif.Q, dif.R);
        end
    endtask

    task automatic test_back_to_back();
        int lat, lat2;
        do_op(8'd100, 8'd7, lat);
        dif.start = 1'b1; dif.A = 8'd50; dif.B = 8'd3;
        lat2 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) dif.start = 1'b0;
            if (dif.done) begin lat2 = c; break; end
        end
        checks++;
        if (lat != 9 || lat2 != 10 || dif.Q !== 8'd16 || dif.R !== 8'd2) begin
            errors++;
            $display("FAIL back_to_back got lat1=%0d lat2=%0d Q=%h R=%h exp 9 10 Q=10 R=02",
                     lat, lat2, dif.Q, dif.R);
        end
    endtask

    task automatic test_reset_abort();
        int ndone, lat;
        ndone = 0;
        @(negedge clk);
        dif.start = 1'b1; dif.A = 8'd100; dif.B = 8'd7;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({dif.busy, dif.done, dif.Q, dif.R, dif.dz, dif.ovf} !== 20'd0) begin
            errors++;
            $display("FAIL reset_abort got busy=%b done=%b Q=%h R=%h dz=%b ovf=%b exp all zero",
                     dif.busy, dif.done, dif.Q, dif.R, dif.dz, dif.ovf);
        end
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (dif.done) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL abort_no_done got dones=%0d exp 0", ndone);
        end
        do_op(8'd9, 8'd2, lat);
        checks++;
        if (lat != 9 || dif.Q !== 8'd4 || dif.R !== 8'd1) begin
            errors++;
            $display("FAIL after_abort got lat=%0d Q=%h R=%h exp 9 04 01", lat, dif.Q, dif.R);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, eq, er;
        logic       edz, eov;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (i % 50 == 7) b = 8'd0;
            model(a, b, eq, er, edz, eov);
            do_op(a, b, lat);
            checks++;
            if (lat != 9 || dif.Q !== eq || dif.R !== er || dif.dz !== edz || dif.ovf !== eov) begin
                errors++;
                $display("FAIL random_%0d A=%h B=%h got lat=%0d Q=%h R=%h dz=%b ovf=%b exp lat=9 Q=%h R=%h dz=%b ovf=%b",
                         i, a, b, lat, dif.Q, dif.R, dif.dz, dif.ovf, eq, er, edz, eov);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
